instr_sequencer: RTL and testbench

Instruction fetch/issue sequencer for the 8-bit CPU: it produces the `Opcode` + `En` stream that the control unit consumes. It holds the program counter, reads 8-bit instructions from a registered instruction ROM, splits each into opcode and operand, and issues one instruction per three cycles. It supports stall, jump redirect and a halt opcode. It sits between the instruction memory and the control unit/datapath.

---
 rtl/instr_sequencer.sv | 123 ++++++++++++
 tb/tb_instr_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : instr_sequencer
//  Purpose  : Instruction fetch/issue sequencer for the 8-bit CPU. Holds the
//             program counter, reads the registered instruction ROM, splits
//             each word into opcode/operand and issues one instruction every
//             three cycles, with stall, jump redirect and a halt opcode.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 8
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic               Stall,
  input  logic               Jump_en,
  input  logic [ADDR_W-1:0]  Jump_addr,
  output logic               Imem_rd,
  output logic [ADDR_W-1:0]  Imem_addr,
  input  logic [INSTR_W-1:0] Imem_data,
  output logic [2:0]         Opcode,
  output logic [INSTR_W-4:0] Operand,
  output logic               En,
  output logic [ADDR_W-1:0]  PC,
  output logic               Halted
);

  // Sequencer states
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  localparam logic [2:0]        OP_HALT = 3'b111;
  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]         state_q,   state_d;
  logic [ADDR_W-1:0]  pc_q,      pc_d;
  logic [2:0]         opcode_q,  opcode_d;
  logic [INSTR_W-4:0] operand_q, operand_d;
  logic               halted_q,  halted_d;
  logic               imem_rd_q;
  logic               halt_op;

  // The halt opcode suppresses issue regardless of Stall.
  assign halt_op = (opcode_q == OP_HALT);

  // Issue strobe is the only combinational output; it reacts to Stall in the same cycle.
  assign En = (state_q == S_ISSUE) && !Stall && !halt_op;

  // Next-state logic: fetch -> latch -> issue loop, with stall hold, jump and halt.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    halted_d  = halted_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        // ROM data is valid now; capture it straight into the issue registers.
        opcode_d  = Imem_data[INSTR_W-1 -: 3];
        operand_d = Imem_data[INSTR_W-4:0];
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        if (halt_op) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else if (!Stall) begin
          // PC advances only on a real issue, so no wrong-path fetch ever happens.
          pc_d    = Jump_en ? Jump_addr : (pc_q + PC_ONE);
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset dominates every other input.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      opcode_q  <= '0;
      operand_q <= '0;
      halted_q  <= 1'b0;
      imem_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      halted_q  <= halted_d;
      // Read strobe is registered from the next state so it is high exactly in FETCH.
      imem_rd_q <= (state_d == S_FETCH);
    end
  end

  assign Imem_rd   = imem_rd_q;
  assign Imem_addr = pc_q;
  assign PC        = pc_q;
  assign Opcode    = opcode_q;
  assign Operand   = operand_q;
  assign Halted    = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_sequencer
//  Purpose  : Self-checking bench for instr_sequencer: registered ROM model,
//             issue scoreboard and hand-timed multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

  logic       Clk;
  logic       Reset_n;
  logic       Start;
  logic       Stall;
  logic       Jump_en;
  logic [4:0] Jump_addr;
  logic       Imem_rd;
  logic [4:0] Imem_addr;
  logic [7:0] Imem_data;
  logic [2:0] Opcode;
  logic [4:0] Operand;
  logic       En;
  logic [4:0] PC;
  logic       Halted;

  instr_sequencer #(.ADDR_W(5), .INSTR_W(8)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .Stall     (Stall),
    .Jump_en   (Jump_en),
    .Jump_addr (Jump_addr),
    .Imem_rd   (Imem_rd),
    .Imem_addr (Imem_addr),
    .Imem_data (Imem_data),
    .Opcode    (Opcode),
    .Operand   (Operand),
    .En        (En),
    .PC        (PC),
    .Halted    (Halted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Registered instruction ROM plus a per-address read counter.
  logic [7:0] rom [32];
  int         rd_count [32];

  always @(posedge Clk) begin
    if (Imem_rd === 1'b1) begin
      Imem_data           <= rom[Imem_addr];
      rd_count[Imem_addr] <= rd_count[Imem_addr] + 1;
    end
  end

  typedef struct {
    logic [4:0] addr;
    logic [7:0] instr;
    logic [2:0] exp_op;
    logic [4:0] exp_opnd;
  } vec_t;

  typedef struct {
    logic [2:0] op;
    logic [4:0] opnd;
    logic [4:0] pc;
    int         gap;
  } exp_t;

  vec_t vecs [4];
  exp_t sb_q [$];
  int   cyc      = 0;
  int   last_en  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rd3, rd9;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [2:0] op, input logic [4:0] opnd, input logic [4:0] pc, input int gap);
    exp_t e;
    e.op   = op;
    e.opnd = opnd;
    e.pc   = pc;
    e.gap  = gap;
    sb_q.push_back(e);
  endtask

  // Settle, then pop the scoreboard on every issue strobe.
  task automatic sample();
    exp_t e;
    #1;
    if (En === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: En=1 Opcode=%0h PC=%0h with nothing expected (cycle %0d)", Opcode, PC, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("issue_opcode",  {29'd0, Opcode},  {29'd0, e.op});
        chk("issue_operand", {27'd0, Operand}, {27'd0, e.opnd});
        chk("issue_pc",      {27'd0, PC},      {27'd0, e.pc});
        if (e.gap != 0) chk("issue_spacing", cyc - last_en, e.gap);
      end
      last_en = cyc;
    end
  endtask

  // One cycle: drive inputs mid-cycle, then sample.
  task automatic drv(input logic rn, input logic st, input logic stl, input logic je, input logic [4:0] ja);
    @(negedge Clk);
    cyc++;
    Reset_n   = rn;
    Start     = st;
    Stall     = stl;
    Jump_en   = je;
    Jump_addr = ja;
    sample();
  endtask

  task automatic idle_cyc();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic wait_issues(input int budget);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      idle_cyc();
      k++;
    end
    chk("sb_drain", sb_q.size(), 0);
  endtask

  task automatic chk_zero();
    chk("zero_imem_rd",   {31'd0, Imem_rd},   32'd0);
    chk("zero_imem_addr", {27'd0, Imem_addr}, 32'd0);
    chk("zero_opcode",    {29'd0, Opcode},    32'd0);
    chk("zero_operand",   {27'd0, Operand},   32'd0);
    chk("zero_en",        {31'd0, En},        32'd0);
    chk("zero_pc",        {27'd0, PC},        32'd0);
    chk("zero_halted",    {31'd0, Halted},    32'd0);
  endtask

  task automatic do_reset();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; Start = 1'b0; Stall = 1'b0; Jump_en = 1'b0; Jump_addr = '0;
    for (int i = 0; i < 32; i++) rom[i] = 8'hE0;

    vecs[0] = '{5'd0, 8'h25, 3'b001, 5'h05};
    vecs[1] = '{5'd1, 8'h5A, 3'b010, 5'h1A};
    vecs[2] = '{5'd2, 8'h9F, 3'b100, 5'h1F};
    vecs[3] = '{5'd3, 8'hC3, 3'b110, 5'h03};

    // ---------------- reset hold and release ----------------
    drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk_zero();
    drv(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    chk_zero();
    drv(1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
    chk_zero();

    // ---------------- sequential program from the table, then halt ----------------
    for (int i = 0; i < 4; i++) begin
      rom[vecs[i].addr] = vecs[i].instr;
      push(vecs[i].exp_op, vecs[i].exp_opnd, vecs[i].addr, (i == 0) ? 0 : 3);
    end
    rom[4] = 8'hE0;
    drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("start_idle_rd", {31'd0, Imem_rd}, 32'd0);
    idle_cyc();
    chk("fetch0_rd",   {31'd0, Imem_rd},   32'd1);
    chk("fetch0_addr", {27'd0, Imem_addr}, 32'd0);
    idle_cyc();
    chk("latch0_rd", {31'd0, Imem_rd}, 32'd0);
    chk("latch0_en", {31'd0, En},      32'd0);
    idle_cyc();
    chk("issue0_en", {31'd0, En}, 32'd1);
    idle_cyc();
    chk("fetch1_addr", {27'd0, Imem_addr}, 32'd1);
    chk("fetch1_rd",   {31'd0, Imem_rd},   32'd1);
    chk("hold_opcode", {29'd0, Opcode},    32'd1);
    wait_issues(20);
    idle_cyc();
    chk("fetch4_addr", {27'd0, Imem_addr}, 32'd4);
    idle_cyc();
    drv(1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
    chk("halt_issue_en",     {31'd0, En},     32'd0);
    chk("halt_issue_opcode", {29'd0, Opcode}, 32'd7);
    chk("halt_issue_halted", {31'd0, Halted}, 32'd0);
    idle_cyc();
    chk("halted_set",  {31'd0, Halted},  32'd1);
    chk("halted_rd",   {31'd0, Imem_rd}, 32'd0);
    chk("halted_pc",   {27'd0, PC},      32'd4);
    for (int i = 0; i < 20; i++) begin
      drv(1'b1, (i % 2) == 0, 1'b0, 1'b0, 5'd0);
      chk("halt_absorb_rd",     {31'd0, Imem_rd}, 32'd0);
      chk("halt_absorb_halted", {31'd0, Halted},  32'd1);
    end
    do_reset();
    chk("halt_reset_halted", {31'd0, Halted}, 32'd0);
    chk("halt_reset_pc",     {27'd0, PC},     32'd0);

    // ---------------- wrap from PC=31 ----------------
    rom[0]  = 8'h20;
    rom[31] = 8'h41;
    push(3'b001, 5'h00, 5'd0, 0);
    push(3'b010, 5'h01, 5'd31, 3);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    idle_cyc();
    idle_cyc();
    drv(1'b1, 1'b0, 1'b0, 1'b1, 5'd31);
    chk("wrap_jump_en", {31'd0, En}, 32'd1);
    idle_cyc();
    chk("wrap_addr31", {27'd0, Imem_addr}, 32'd31);
    idle_cyc();
    idle_cyc();
    chk("wrap_issue_en", {31'd0, En}, 32'd1);
    idle_cyc();
    chk("wrap_addr0", {27'd0, Imem_addr}, 32'd0);
    chk("wrap_rd",    {31'd0, Imem_rd},   32'd1);
    do_reset();
    chk("wrap_sb_empty", sb_q.size(), 0);

    // ---------------- stall, ignored jumps, jump redirect ----------------
    rom[0]  = 8'h3B;
    rom[1]  = 8'h64;
    rom[2]  = 8'hC0;
    rom[3]  = 8'hE0;
    rom[20] = 8'h8A;
    rom[21] = 8'hE0;
    rd3 = rd_count[3];
    rd9 = rd_count[9];
    push(3'b001, 5'h1B, 5'd0, 0);
    push(3'b011, 5'h04, 5'd1, 3);
    push(3'b110, 5'h00, 5'd2, 3);
    push(3'b100, 5'h0A, 5'd20, 3);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    idle_cyc();
    drv(1'b1, 1'b0, 1'b0, 1'b1, 5'd9);
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 1'b0, 1'b1, i == 0, 5'd9);
      chk("stall_en",      {31'd0, En},      32'd0);
      chk("stall_opcode",  {29'd0, Opcode},  32'd1);
      chk("stall_operand", {27'd0, Operand}, 32'h1B);
    end
    idle_cyc();
    chk("stall_release_en", {31'd0, En}, 32'd1);
    idle_cyc();
    chk("stall_pc_once",   {27'd0, PC},        32'd1);
    chk("stall_fetch_addr", {27'd0, Imem_addr}, 32'd1);
    idle_cyc();
    idle_cyc();
    idle_cyc();
    idle_cyc();
    drv(1'b1, 1'b0, 1'b0, 1'b1, 5'd20);
    chk("jump_issue_en", {31'd0, En}, 32'd1);
    idle_cyc();
    chk("jump_target_addr", {27'd0, Imem_addr}, 32'd20);
    chk("jump_target_rd",   {31'd0, Imem_rd},   32'd1);
    wait_issues(10);
    for (int i = 0; i < 4; i++) idle_cyc();
    chk("jump_halted",       {31'd0, Halted}, 32'd1);
    chk("jump_no_wrong_path", rd_count[3], rd3);
    chk("latch_jump_ignored", rd_count[9], rd9);
    do_reset();

    // ---------------- reset during LATCH and during a stalled ISSUE ----------------
    rom[0] = 8'hA7;
    rom[1] = 8'h5C;
    push(3'b101, 5'h07, 5'd0, 0);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    idle_cyc();
    idle_cyc();
    idle_cyc();
    chk("midrst_issue_en", {31'd0, En}, 32'd1);
    idle_cyc();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("midrst_pre_opcode", {29'd0, Opcode}, 32'd5);
    idle_cyc();
    chk_zero();
    idle_cyc();
    chk("midrst_idle_rd", {31'd0, Imem_rd}, 32'd0);
    drv(1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
    idle_cyc();
    chk("midrst_refetch_addr", {27'd0, Imem_addr}, 32'd0);
    idle_cyc();
    drv(1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
    chk("midrst_stall_en",     {31'd0, En},     32'd0);
    chk("midrst_stall_opcode", {29'd0, Opcode}, 32'd5);
    drv(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
    drv(1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
    chk("midrst2_en",     {31'd0, En},      32'd0);
    chk("midrst2_rd",     {31'd0, Imem_rd}, 32'd0);
    chk("midrst2_opcode", {29'd0, Opcode},  32'd0);
    chk("midrst2_pc",     {27'd0, PC},      32'd0);
    idle_cyc();
    chk("midrst2_idle_rd", {31'd0, Imem_rd}, 32'd0);
    chk("final_sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
